lsm_regress_seq: RTL and testbench
==================================

Name: lsm_regress_seq

Overview:
- Sequencer for the least-squares regression step of the Longstaff–Schwartz pricing pipeline.
- Per exercise date it clears and feeds the XTX/XTY accumulators with in-the-money (ITM) path samples, then starts MAT_INV and waits for its result.
- Reports completion, degenerate regressions and inverter timeouts to the top-level pricing FSM.
- Sits between the path-sample stream and the XTX/XTY/MAT_INV datapath; it carries no data, only control.

Parameters:
- PATH_W, 10, width of the path counters; max paths per date = 2^PATH_W-1.
- ACC_LAT, 2, cycles from the last acc_en to stable accumulator outputs.
- INV_TIMEOUT, 64, max cycles waiting for inv_valid after inv_start rises.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- cmd_start  in  1  begin one regression; sampled only in IDLE.
- cfg_n_paths  in  PATH_W  number of path samples for this date; latched on accepted cmd_start.
- s_valid  in  1  path sample present.
- s_itm  in  1  sample is in-the-money (qualified by s_valid).
- s_ready  out  1  controller accepts sample this cycle.
- acc_clr  out  1  clear XTX/XTY accumulators.
- acc_en  out  1  accumulate current sample (same cycle as handshake).
- inv_start  out  1  level start to MAT_INV.
- inv_valid  in  1  MAT_INV o_valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- degenerate  out  1  fewer than 3 ITM samples; inversion skipped.
- err_timeout  out  1  MAT_INV did not respond within INV_TIMEOUT.
- itm_count  out  PATH_W  ITM samples accumulated for this date.

Behaviour:
- Reset: state=IDLE; every output 0, including itm_count; all counters 0. Reset mid-operation returns to IDLE at that edge and inv_start drops the same edge. No partial done pulse.
- States: IDLE, CLEAR, ACCUM, DRAIN, INVERT, DONE.
- IDLE:
  - cmd_start=1 with cfg_n_paths≠0: latch n, clear degenerate, err_timeout, itm_count and path_cnt, go to CLEAR.
  - cmd_start=1 with cfg_n_paths=0: go to DONE with degenerate=1.
- CLEAR: acc_clr=1 for exactly one cycle, then ACCUM.
- ACCUM:
  - s_ready=1 combinationally.
  - Handshake = s_valid & s_ready; it increments path_cnt.
  - acc_en = handshake & s_itm, combinational, so accumulators capture data on the same edge; itm_count increments on the same edge.
  - The handshake that makes path_cnt equal n moves to DRAIN. No further samples are accepted.
  - s_valid gaps are allowed; there is no timeout in ACCUM.
- DRAIN:
  - s_ready=0; wait ACC_LAT cycles.
  - Then itm_count<3 goes to DONE with degenerate=1; otherwise go to INVERT.
- INVERT:
  - inv_start=1 held from entry until the cycle inv_valid=1 is sampled, then DONE. inv_start is 0 in DONE.
  - A wait counter starts at 0 on entry; on reaching INV_TIMEOUT without inv_valid, set err_timeout=1 and go to DONE.
  - inv_valid in the same cycle the counter expires counts as success.
- DONE: done=1 for one cycle, then IDLE.
- degenerate, err_timeout and itm_count hold until the next accepted cmd_start.
- inv_valid outside INVERT is ignored. cmd_start while busy is ignored and not queued. s_valid outside ACCUM is not acknowledged.
- Latency with back-to-back samples: done rises 1(CLEAR)+N+ACC_LAT+T_inv+1 cycles after the accepted cmd_start edge.
- Counter widths:
  - path_cnt and itm_count are PATH_W bits and cannot wrap, since itm_count ≤ path_cnt ≤ n ≤ 2^PATH_W-1.
  - The timeout counter is clog2(INV_TIMEOUT+1) bits.

Test Plan:
- Reset then cmd_start, n=8, 8 back-to-back samples with 5 ITM; MAT_INV model responds 4 cycles after inv_start -> expected sequence:
  - acc_clr one cycle; s_ready 8 cycles; acc_en 5 pulses.
  - inv_start high 4 cycles; done 1+8+2+4+1 cycles after start.
  - itm_count=5, degenerate=0, err_timeout=0.
- n=6 with s_valid gaps, 2 ITM -> no inv_start; done after DRAIN; degenerate=1, itm_count=2.
- n=4, all ITM, inv_valid never asserted -> inv_start high exactly 64 cycles, then err_timeout=1 and done pulse; busy falls next cycle.
- cmd_start with cfg_n_paths=0 -> done 1 cycle after start, degenerate=1, no acc_clr, no inv_start.
- rst asserted in INVERT and in ACCUM -> all outputs 0 at that edge. Next cmd_start, n=3 all ITM, runs cleanly with itm_count=3.
- Stray stimulus: cmd_start pulses and inv_valid pulses during ACCUM, and inv_valid in IDLE -> no state change, no extra done. A second cmd_start held during DONE is accepted only after IDLE is re-entered.

Source files
------------

// File: rtl/lsm_regress_seq.sv
// Control sequencer for the Longstaff-Schwartz regression step: clears and feeds the
// XTX/XTY accumulators with ITM samples, kicks MAT_INV, and reports the outcome.
module lsm_regress_seq #(
    parameter int PATH_W      = 10,
    parameter int ACC_LAT     = 2,
    parameter int INV_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_start,
    input  logic [PATH_W-1:0] cfg_n_paths,
    input  logic              s_valid,
    input  logic              s_itm,
    output logic              s_ready,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              inv_start,
    input  logic              inv_valid,
    output logic              busy,
    output logic              done,
    output logic              degenerate,
    output logic              err_timeout,
    output logic [PATH_W-1:0] itm_count
);
    localparam int TO_W  = $clog2(INV_TIMEOUT + 1);
    localparam int LAT_W = $clog2(ACC_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN, S_INVERT, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [PATH_W-1:0] n_q, path_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic [TO_W-1:0]   wait_cnt;
    logic              hs, last_hs, lat_done, to_hit, few_itm;

    assign hs       = (state == S_ACCUM) && s_valid;
    assign last_hs  = hs && (path_cnt == n_q - PATH_W'(1));
    assign lat_done = (lat_cnt == LAT_W'(ACC_LAT - 1));
    assign to_hit   = (wait_cnt == TO_W'(INV_TIMEOUT - 1));
    assign few_itm  = (itm_count < PATH_W'(3));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        inv_start = 1'b0;
        done      = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (cmd_start)
                    state_nxt = (cfg_n_paths == '0) ? S_DONE : S_CLEAR;
            end
            S_CLEAR: begin
                acc_clr   = 1'b1;
                state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                s_ready = 1'b1;
                acc_en  = s_valid && s_itm;
                if (last_hs) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (lat_done) state_nxt = few_itm ? S_DONE : S_INVERT;
            end
            S_INVERT: begin
                inv_start = 1'b1;
                // a response on the expiry cycle still wins over the timeout
                if (inv_valid || to_hit) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q         <= '0;
            path_cnt    <= '0;
            itm_count   <= '0;
            lat_cnt     <= '0;
            wait_cnt    <= '0;
            degenerate  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            lat_cnt  <= '0;
            wait_cnt <= '0;
            case (state)
                S_IDLE: begin
                    if (cmd_start) begin
                        n_q         <= cfg_n_paths;
                        path_cnt    <= '0;
                        itm_count   <= '0;
                        err_timeout <= 1'b0;
                        degenerate  <= (cfg_n_paths == '0);
                    end
                end
                S_ACCUM: begin
                    if (hs) begin
                        path_cnt <= path_cnt + PATH_W'(1);
                        if (s_itm) itm_count <= itm_count + PATH_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (!lat_done)    lat_cnt    <= lat_cnt + LAT_W'(1);
                    else if (few_itm) degenerate <= 1'b1;
                end
                S_INVERT: begin
                    wait_cnt <= wait_cnt + TO_W'(1);
                    if (to_hit && !inv_valid) err_timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lsm_regress_seq.sv
// Bench for lsm_regress_seq: directed vector table plus randomized runs, each checked
// cycle by cycle against a phase timeline derived from n, the valid pattern and MAT_INV delay.
module tb_lsm_regress_seq;
    localparam int PATH_W      = 10;
    localparam int ACC_LAT     = 2;
    localparam int INV_TIMEOUT = 64;
    localparam int MAXC        = 400;
    localparam logic [63:0] ONES = '1;

    logic              clk = 1'b0, rst = 1'b1, cmd_start = 1'b0;
    logic [PATH_W-1:0] cfg_n_paths = '0;
    logic              s_valid = 1'b0, s_itm = 1'b0, inv_valid = 1'b0;
    logic              s_ready, acc_clr, acc_en, inv_start, busy, done, degenerate, err_timeout;
    logic [PATH_W-1:0] itm_count;

    lsm_regress_seq #(.PATH_W(PATH_W), .ACC_LAT(ACC_LAT), .INV_TIMEOUT(INV_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cfg_n_paths(cfg_n_paths),
        .s_valid(s_valid), .s_itm(s_itm), .s_ready(s_ready), .acc_clr(acc_clr),
        .acc_en(acc_en), .inv_start(inv_start), .inv_valid(inv_valid), .busy(busy),
        .done(done), .degenerate(degenerate), .err_timeout(err_timeout), .itm_count(itm_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s case %0d: got %0h want %0h", name, id, got, want);
        end
    endtask

    typedef struct {
        int          n;
        logic [63:0] itm;
        logic [63:0] vmask;   // bit i = s_valid in the i-th ACCUM cycle
        int          inv_d;   // MAT_INV answers in its d-th INVERT cycle; out of 1..64 = never
        int          rst_at;  // cycle in which rst is raised, 0 = none
        bit          stray;
        int          e_itm;
        bit          e_deg;
        bit          e_err;
        int          e_done;
        int          e_inv;
    } vec_t;

    // Cycle c=1 is the first cycle after the edge that accepts cmd_start.
    task automatic run_case(input int id, input int n, input logic [63:0] itm, input logic [63:0] vmask,
                            input bit rnd, input int inv_d, input int rst_at, input bit stray,
                            output int o_done, output int o_inv, output int o_itm,
                            output bit o_deg, output bit o_err);
        logic       v [0:MAXC];
        int         kidx [0:MAXC];
        int         k, a_end, pop, t_inv, i_start, done_c;
        bit         deg, ok_inv, err, in_inv, in_acc;
        logic [5:0] want;
        k = 0; a_end = -1; pop = 0;
        o_done = -1; o_inv = 0; o_itm = -1; o_deg = 1'b0; o_err = 1'b0;
        for (int c = 0; c <= MAXC; c++) begin
            if (c < 2)    v[c] = 1'($urandom);
            else if (rnd) v[c] = ($urandom_range(0, 3) != 0);
            else          v[c] = (c - 2 < 64) ? vmask[c-2] : 1'b1;
            kidx[c] = k;
            if (c >= 2 && k < n && v[c]) begin
                k++;
                if (k == n) a_end = c;
            end
        end
        for (int i = 0; i < n; i++) pop += int'(itm[i]);
        deg     = (n == 0) || (pop < 3);
        ok_inv  = (inv_d >= 1) && (inv_d <= INV_TIMEOUT);
        err     = !deg && !ok_inv;
        t_inv   = deg ? 0 : (ok_inv ? inv_d : INV_TIMEOUT);
        i_start = a_end + ACC_LAT + 1;
        done_c  = (n == 0) ? 1 : i_start + t_inv;
        if (n != 0 && a_end < 0) begin
            chk("accum_budget", id, 0, 1);
            return;
        end

        @(negedge clk);
        cmd_start = 1'b1; cfg_n_paths = PATH_W'(n);
        s_valid = v[0]; inv_valid = stray;
        @(posedge clk);
        for (int c = 1; c <= done_c + 1; c++) begin
            #1;
            in_acc      = (n != 0) && (c >= 2) && (c <= a_end);
            in_inv      = !deg && (c >= i_start) && (c < done_c);
            cmd_start   = stray && (c >= 2) && (c < done_c) && ($urandom_range(0, 2) == 0);
            cfg_n_paths = PATH_W'($urandom);
            s_valid     = v[c];
            s_itm       = (c >= 2 && kidx[c] < n) ? itm[kidx[c]] : 1'($urandom);
            inv_valid   = in_inv ? (ok_inv && c == i_start + inv_d - 1) : (stray && $urandom_range(0, 1) == 1);
            rst         = (c == rst_at);
            #1;
            want = {(n != 0) && (c == 1), in_acc, in_acc && v[c] && s_itm, in_inv,
                    (c >= 1) && (c <= done_c), c == done_c};
            chk("cycle_outputs", id, {acc_clr, s_ready, acc_en, inv_start, busy, done}, want);
            if (done && o_done < 0) o_done = c;
            if (inv_start) o_inv++;
            @(posedge clk);
            if (c == rst_at) begin
                #1;
                rst = 1'b0; cmd_start = 1'b0; s_valid = 1'b0; inv_valid = 1'b0;
                #1;
                chk("reset_outputs", id,
                    {acc_clr, s_ready, acc_en, inv_start, busy, done, degenerate, err_timeout, itm_count}, 0);
                o_itm = itm_count; o_deg = degenerate; o_err = err_timeout;
                return;
            end
        end
        #1;
        cmd_start = 1'b0; s_valid = 1'b0; inv_valid = 1'b0;
        #1;
        chk("itm_count", id, itm_count, pop);
        chk("degenerate", id, degenerate, deg);
        chk("err_timeout", id, err_timeout, err);
        o_itm = itm_count; o_deg = degenerate; o_err = err_timeout;
    endtask

    vec_t tbl [11];
    int   r_done, r_inv, r_itm;
    bit   r_deg, r_err;

    initial begin
        //          n  itm      vmask                  d   rst st itm deg err done inv
        tbl[0]  = '{8, 64'hB5,  ONES,                  4,  0,  0, 5,  0,  0,  16,  4};
        tbl[1]  = '{6, 64'h22,  64'hFFFF_FFFF_FFFF_F34D, 4, 0, 0, 2,  1,  0,  14,  0};
        tbl[2]  = '{4, 64'hF,   ONES,                  0,  0,  0, 4,  0,  1,  72,  64};
        tbl[3]  = '{0, 64'h0,   ONES,                  0,  0,  0, 0,  1,  0,  1,   0};
        tbl[4]  = '{8, 64'hFF,  ONES,                  3,  5,  0, 0,  0,  0,  -1,  -1};
        tbl[5]  = '{3, 64'h7,   ONES,                  1,  0,  0, 3,  0,  0,  8,   1};
        tbl[6]  = '{4, 64'hF,   ONES,                  0,  20, 0, 0,  0,  0,  -1,  -1};
        tbl[7]  = '{3, 64'h7,   ONES,                  64, 0,  0, 3,  0,  0,  71,  64};
        tbl[8]  = '{3, 64'h7,   ONES,                  65, 0,  0, 3,  0,  1,  71,  64};
        tbl[9]  = '{5, 64'h7,   ONES,                  3,  0,  1, 3,  0,  0,  12,  3};
        tbl[10] = '{3, 64'h3,   ONES,                  1,  0,  0, 2,  1,  0,  7,   0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 0,
            {acc_clr, s_ready, acc_en, inv_start, busy, done, degenerate, err_timeout, itm_count}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_case(i, tbl[i].n, tbl[i].itm, tbl[i].vmask, 1'b0, tbl[i].inv_d, tbl[i].rst_at,
                     tbl[i].stray, r_done, r_inv, r_itm, r_deg, r_err);
            chk("tbl_itm", i, r_itm, tbl[i].e_itm);
            chk("tbl_deg", i, r_deg, tbl[i].e_deg);
            chk("tbl_err", i, r_err, tbl[i].e_err);
            if (tbl[i].rst_at == 0) begin
                chk("tbl_done_cycle", i, r_done, tbl[i].e_done);
                chk("tbl_inv_cycles", i, r_inv, tbl[i].e_inv);
            end
        end

        // cmd_start held through DONE is only taken once IDLE is re-entered
        @(negedge clk);
        cmd_start = 1'b1; cfg_n_paths = '0;
        @(posedge clk); #1;
        chk("held_c1_busy_done", 100, {busy, done}, 2'b11);
        @(posedge clk); #1;
        chk("held_c2_idle", 100, {busy, done}, 2'b00);
        @(posedge clk); #1;
        chk("held_c3_busy_done", 100, {busy, done}, 2'b11);
        cmd_start = 1'b0;
        @(posedge clk); #1;
        chk("held_c4_idle", 100, {busy, done, degenerate}, 3'b001);

        for (int i = 0; i < 25; i++) begin
            run_case(200 + i, $urandom_range(0, 40), {$urandom, $urandom}, ONES, 1'b1,
                     $urandom_range(1, 70), 0, 1'($urandom), r_done, r_inv, r_itm, r_deg, r_err);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
